hex_scroll_decoder: RTL and testbench

//  Receiving end of the scrolling-display shift stream: samples each 7-seg pattern shifted into HEX0,

---
 rtl/scroll_dec_pkg.sv | 63 ++++++
 rtl/scroll_char_fifo.sv | 59 +++++
 rtl/hex_scroll_decoder.sv | 156 +++++++++++++++
 tb/tb_hex_scroll_decoder.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_dec_pkg.sv
// Shared types for the scrolling-display reader: character codes, FSM states,
// the active-low 7-segment patterns the scroller emits, and the decoder.
package scroll_dec_pkg;

   localparam int SEG_W  = 7;
   localparam int CHAR_W = 5;

   localparam int DEFAULT_FIFO_DEPTH = 4;
   localparam int DEFAULT_BLANK_RUN  = 6;

   typedef enum logic [CHAR_W-1:0] {
      CH_BLANK = 5'd0,
      CH_C     = 5'd1,
      CH_P     = 5'd2,
      CH_E     = 5'd3,
      CH_N     = 5'd4,
      CH_3     = 5'd5,
      CH_1     = 5'd6,
      CH_LB    = 5'd7,   // lower-case b
      CH_Y     = 5'd8,
      CH_LE    = 5'd9,   // lower-case e
      CH_UNK   = 5'd31
   } char_t;

   typedef enum logic [1:0] {
      IDLE,
      IN_WORD,
      GAP,
      DONE
   } state_t;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_C   = 7'b1000110;
   localparam logic [SEG_W-1:0] SEG_P   = 7'b0001100;
   localparam logic [SEG_W-1:0] SEG_E   = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_N   = 7'b1001000;
   localparam logic [SEG_W-1:0] SEG_3   = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_1   = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_LB  = 7'b0000011;
   localparam logic [SEG_W-1:0] SEG_Y   = 7'b0010001;
   localparam logic [SEG_W-1:0] SEG_LE  = 7'b0000100;

   // Map a raw segment pattern to its character code; anything else is UNK
   function automatic char_t seg_to_char(input logic [SEG_W-1:0] seg);
      char_t code;
      case (seg)
         SEG_OFF: code = CH_BLANK;
         SEG_C:   code = CH_C;
         SEG_P:   code = CH_P;
         SEG_E:   code = CH_E;
         SEG_N:   code = CH_N;
         SEG_3:   code = CH_3;
         SEG_1:   code = CH_1;
         SEG_LB:  code = CH_LB;
         SEG_Y:   code = CH_Y;
         SEG_LE:  code = CH_LE;
         default: code = CH_UNK;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/scroll_char_fifo.sv
// Small synchronous FIFO of decoded characters. Head data is read
// combinationally so a code pushed on one edge is visible right after it.
// A push while full is accepted only if the same cycle pops.
module scroll_char_fifo
   import scroll_dec_pkg::*;
#(
   parameter int DEPTH = DEFAULT_FIFO_DEPTH   // power of 2, >= 2
) (
   input  logic  clk,
   input  logic  reset_n,
   input  logic  push,
   input  char_t push_data,
   input  logic  pop,
   output logic  full,
   output logic  empty,
   output char_t head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   char_t         mem [DEPTH];

   logic do_pop;
   logic do_push;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? CH_BLANK : mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array write port
   // NOTE: storage is deliberately not reset; count gates every read, so stale
   // entries are never observed and the array can map onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/hex_scroll_decoder.sv
// Reader for the scrolling 7-segment shift stream: decodes every pattern
// shifted into HEX0, queues character codes behind a valid/ready port and
// flags word and message boundaries.
// Optional feature macro: SCROLL_MIRROR_EN adds mirror_hex0..mirror_hex5,
// a copy of the six digits as the scroller has shifted them.
// BLANK_RUN is expected to be >= 2 (the first blank only ends the word).
module hex_scroll_decoder
   import scroll_dec_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int BLANK_RUN  = DEFAULT_BLANK_RUN
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             shift_en,
   input  logic [SEG_W-1:0] seg_in,
   input  logic             char_ready,
   output logic             char_valid,
   output logic [CHAR_W-1:0] char_code,
   output logic             word_done,
   output logic             msg_done,
   output logic [7:0]       msg_count,
   output logic             decode_err,
   output logic             overflow
`ifdef SCROLL_MIRROR_EN
   ,
   output logic [SEG_W-1:0] mirror_hex0,
   output logic [SEG_W-1:0] mirror_hex1,
   output logic [SEG_W-1:0] mirror_hex2,
   output logic [SEG_W-1:0] mirror_hex3,
   output logic [SEG_W-1:0] mirror_hex4,
   output logic [SEG_W-1:0] mirror_hex5
`endif
);

   localparam int                CNT_W    = $clog2(BLANK_RUN + 1);
   localparam logic [CNT_W-1:0]  RUN_MAX  = CNT_W'(BLANK_RUN);
   localparam logic [CNT_W-1:0]  RUN_LAST = CNT_W'(BLANK_RUN - 1);

   state_t           state;
   logic [CNT_W-1:0] blank_cnt;

   char_t seg_char;
   logic  is_blank;
   logic  push;
   logic  pop;
   logic  fifo_full;
   logic  fifo_empty;
   char_t fifo_head;

   assign seg_char = seg_to_char(seg_in);
   assign is_blank = (seg_char == CH_BLANK);

   // Non-blank characters are always queued; the one blank that closes a
   // word is queued too (its code is BLANK), further blanks are not.
   assign push = shift_en & (~is_blank | (state == IN_WORD));
   assign pop  = char_valid & char_ready;

   assign char_valid = ~fifo_empty;
   assign char_code  = fifo_head;

   scroll_char_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (seg_char),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   // Word/message FSM with blank-run counter, boundary pulses and sticky flags
   // NOTE: all state here updates with <= so every branch reads the values
   // from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         blank_cnt  <= '0;
         word_done  <= 1'b0;
         msg_done   <= 1'b0;
         msg_count  <= '0;
         decode_err <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         word_done <= 1'b0;
         msg_done  <= 1'b0;

         if (push && fifo_full && !pop) overflow <= 1'b1;

         if (shift_en) begin
            if (seg_char == CH_UNK) decode_err <= 1'b1;

            case (state)
               IDLE: begin
                  if (!is_blank) begin
                     state     <= IN_WORD;
                     blank_cnt <= '0;
                  end
               end
               IN_WORD: begin
                  if (is_blank) begin
                     state     <= GAP;
                     word_done <= 1'b1;
                     blank_cnt <= CNT_W'(1);
                  end
               end
               GAP: begin
                  if (is_blank) begin
                     if (blank_cnt < RUN_MAX) blank_cnt <= blank_cnt + CNT_W'(1);
                     if (blank_cnt == RUN_LAST) begin
                        state     <= DONE;
                        msg_done  <= 1'b1;
                        msg_count <= msg_count + 8'd1;
                     end
                  end else begin
                     state     <= IN_WORD;
                     blank_cnt <= '0;
                  end
               end
               DONE: begin
                  if (!is_blank) begin
                     state     <= IN_WORD;
                     blank_cnt <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef SCROLL_MIRROR_EN
   logic [SEG_W-1:0] mirror [6];

   // Shadow of the six display digits, shifted in step with the scroller
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 6; i++) mirror[i] <= SEG_OFF;
      end else if (shift_en) begin
         mirror[0] <= seg_in;
         for (int i = 1; i < 6; i++) mirror[i] <= mirror[i-1];
      end
   end

   assign mirror_hex0 = mirror[0];
   assign mirror_hex1 = mirror[1];
   assign mirror_hex2 = mirror[2];
   assign mirror_hex3 = mirror[3];
   assign mirror_hex4 = mirror[4];
   assign mirror_hex5 = mirror[5];
`endif

endmodule

// File: tb/tb_hex_scroll_decoder.sv
// Self-checking bench for hex_scroll_decoder. A queue-based reference model
// tracks the decoded-character stream, word/message boundaries and flags.
// Build with SCROLL_MIRROR_EN defined to also exercise the mirror outputs.
module tb_hex_scroll_decoder;

   localparam int DEPTH = 4;
   localparam int RUN   = 6;

   localparam logic [6:0] P_OFF = 7'h7F;
   localparam logic [6:0] P_C   = 7'b1000110;
   localparam logic [6:0] P_P   = 7'b0001100;
   localparam logic [6:0] P_E   = 7'b0000110;
   localparam logic [6:0] P_N   = 7'b1001000;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       shift_en;
   logic [6:0] seg_in;
   logic       char_ready;
   logic       char_valid;
   logic [4:0] char_code;
   logic       word_done;
   logic       msg_done;
   logic [7:0] msg_count;
   logic       decode_err;
   logic       overflow;
`ifdef SCROLL_MIRROR_EN
   logic [6:0] mirror_hex0, mirror_hex1, mirror_hex2;
   logic [6:0] mirror_hex3, mirror_hex4, mirror_hex5;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hex_scroll_decoder #(
      .FIFO_DEPTH (DEPTH),
      .BLANK_RUN  (RUN)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .shift_en   (shift_en),
      .seg_in     (seg_in),
      .char_ready (char_ready),
      .char_valid (char_valid),
      .char_code  (char_code),
      .word_done  (word_done),
      .msg_done   (msg_done),
      .msg_count  (msg_count),
      .decode_err (decode_err),
      .overflow   (overflow)
`ifdef SCROLL_MIRROR_EN
      ,
      .mirror_hex0 (mirror_hex0),
      .mirror_hex1 (mirror_hex1),
      .mirror_hex2 (mirror_hex2),
      .mirror_hex3 (mirror_hex3),
      .mirror_hex4 (mirror_hex4),
      .mirror_hex5 (mirror_hex5)
`endif
   );

   // ---------------- reference model ----------------
   // Character table indexed by code (0 = blank).
   logic [6:0] pat [10] = '{7'h7F, 7'b1000110, 7'b0001100, 7'b0000110, 7'b1001000,
                            7'b0110000, 7'b1111001, 7'b0000011, 7'b0010001, 7'b0000100};

   int         m_q[$];
   bit         m_last_nonblank;  // previous shifted character was a letter
   bit         m_msg_open;       // a message has started and not yet ended
   int         m_blank_run;      // consecutive blanks shifted so far
   logic [7:0] m_msgs;
   bit         m_err;
   bit         m_ovf;
   bit         m_word;
   bit         m_msg;
   bit         exp_valid;
   int         exp_code;

   function automatic int model_decode(input logic [6:0] s);
      for (int i = 0; i < 10; i++) if (s == pat[i]) return i;
      return 31;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_last_nonblank = 0;
      m_msg_open      = 0;
      m_blank_run     = 0;
      m_msgs          = 8'd0;
      m_err           = 0;
      m_ovf           = 0;
      m_word          = 0;
      m_msg           = 0;
      exp_valid       = 0;
      exp_code        = 0;
   endtask

   task automatic model_push(input int code, input bit popping);
      if (m_q.size() == DEPTH && !popping) m_ovf = 1;
      else m_q.push_back(code);
   endtask

   // One clock: drive inputs at the falling edge, update the model, let the
   // DUT take the rising edge, and return at the next falling edge.
   task automatic step(input logic sh, input logic [6:0] seg, input logic rdy);
      bit popping;
      int code;
      shift_en   = sh;
      seg_in     = seg;
      char_ready = rdy;
      popping    = rdy && (m_q.size() > 0);
      m_word     = 0;
      m_msg      = 0;
      if (sh) begin
         code = model_decode(seg);
         if (code == 31) m_err = 1;
         if (code != 0) begin
            model_push(code, popping);
            m_last_nonblank = 1;
            m_msg_open      = 1;
            m_blank_run     = 0;
         end else begin
            m_blank_run++;
            if (m_last_nonblank) begin
               model_push(0, popping);
               m_word = 1;
            end
            m_last_nonblank = 0;
            if (m_msg_open && m_blank_run == RUN) begin
               m_msg      = 1;
               m_msgs     = m_msgs + 8'd1;
               m_msg_open = 0;
            end
         end
      end
      if (popping) void'(m_q.pop_front());
      @(posedge clk);
      @(negedge clk);
      shift_en  = 1'b0;
      exp_valid = (m_q.size() > 0);
      exp_code  = exp_valid ? m_q[0] : 0;
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      shift_en   = 1'b0;
      seg_in     = 7'h7F;
      char_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if ({char_valid, char_code, word_done, msg_done, msg_count, decode_err, overflow} !== 18'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0",
                  {char_valid, char_code, word_done, msg_done, msg_count, decode_err, overflow});
      end
   endtask

   task automatic test_word();
      logic [6:0] seq [4];
      seq = '{P_C, P_P, P_E, P_N};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, seq[i], 1'b1);
         checks++;
         if (char_valid !== 1'b1 || char_code !== 5'(i + 1) || char_code !== 5'(exp_code)) begin
            failures++;
            $display("FAIL word_char[%0d] got valid=%b code=%0d exp valid=1 code=%0d",
                     i, char_valid, char_code, i + 1);
         end
      end
   endtask

   task automatic test_message();
      do_reset();
      step(1'b1, P_N, 1'b1);
      for (int i = 0; i < RUN; i++) begin
         step(1'b1, P_OFF, 1'b1);
         checks++;
         if (word_done !== (i == 0) || word_done !== m_word) begin
            failures++;
            $display("FAIL msg_word_done[%0d] got=%b exp=%b", i, word_done, (i == 0));
         end
         checks++;
         if (msg_done !== (i == RUN - 1) || msg_done !== m_msg) begin
            failures++;
            $display("FAIL msg_msg_done[%0d] got=%b exp=%b", i, msg_done, (i == RUN - 1));
         end
         checks++;
         if (char_valid !== exp_valid || char_code !== 5'(exp_code)) begin
            failures++;
            $display("FAIL msg_fifo[%0d] got valid=%b code=%0d exp valid=%b code=%0d",
                     i, char_valid, char_code, exp_valid, exp_code);
         end
      end
      checks++;
      if (msg_count !== 8'd1) begin
         failures++;
         $display("FAIL msg_count got=%0d exp=1", msg_count);
      end
   endtask

   task automatic test_overflow();
      logic [6:0] seq [5];
      seq = '{P_C, P_P, P_E, P_N, 7'b0110000};
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, seq[i], 1'b0);
      checks++;
      if (overflow !== 1'b1 || m_ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_flag got=%b exp=1", overflow);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (char_valid !== 1'b1 || char_code !== 5'(i + 1)) begin
            failures++;
            $display("FAIL ovf_pop[%0d] got valid=%b code=%0d exp valid=1 code=%0d",
                     i, char_valid, char_code, i + 1);
         end
         step(1'b0, P_OFF, 1'b1);
      end
      checks++;
      if (char_valid !== 1'b0 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL ovf_drained got valid=%b ovf=%b exp valid=0 ovf=1", char_valid, overflow);
      end
   endtask

   task automatic test_decode_err();
      do_reset();
      step(1'b1, 7'h00, 1'b0);
      checks++;
      if (char_code !== 5'd31 || decode_err !== 1'b1) begin
         failures++;
         $display("FAIL err_unk got code=%0d err=%b exp code=31 err=1", char_code, decode_err);
      end
      step(1'b1, P_E, 1'b1);
      step(1'b1, P_P, 1'b1);
      checks++;
      if (decode_err !== 1'b1 || char_code !== 5'(exp_code)) begin
         failures++;
         $display("FAIL err_sticky got err=%b code=%0d exp err=1 code=%0d",
                  decode_err, char_code, exp_code);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(1'b1, P_C, 1'b0);
      step(1'b1, 7'h00, 1'b0);
      step(1'b1, P_OFF, 1'b0);
      checks++;
      if (m_q.size() != 3 || char_valid !== 1'b1 || word_done !== 1'b1 || decode_err !== 1'b1) begin
         failures++;
         $display("FAIL arst_setup got valid=%b word=%b err=%b exp 1 1 1",
                  char_valid, word_done, decode_err);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({char_valid, char_code, word_done, msg_done, msg_count, decode_err, overflow} !== 18'd0) begin
         failures++;
         $display("FAIL arst_outputs got=%b exp=0",
                  {char_valid, char_code, word_done, msg_done, msg_count, decode_err, overflow});
      end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      // Back in IDLE: a full blank run must neither queue nor end a message.
      for (int i = 0; i < RUN; i++) begin
         step(1'b1, P_OFF, 1'b1);
         checks++;
         if (char_valid !== 1'b0 || msg_done !== 1'b0 || word_done !== 1'b0) begin
            failures++;
            $display("FAIL arst_idle[%0d] got valid=%b msg=%b word=%b exp 0 0 0",
                     i, char_valid, msg_done, word_done);
         end
      end
      step(1'b1, P_N, 1'b1);
      checks++;
      if (char_valid !== 1'b1 || char_code !== 5'd4 || msg_count !== 8'd0) begin
         failures++;
         $display("FAIL arst_resume got valid=%b code=%0d cnt=%0d exp 1 4 0",
                  char_valid, char_code, msg_count);
      end
   endtask

   task automatic test_msg_wrap();
      do_reset();
      for (int m = 0; m < 256; m++) begin
         step(1'b1, P_N, 1'b1);
         for (int i = 0; i < RUN; i++) step(1'b1, P_OFF, 1'b1);
         checks++;
         if (msg_count !== m_msgs || msg_count !== 8'((m + 1) % 256)) begin
            failures++;
            $display("FAIL wrap_count[%0d] got=%0d exp=%0d", m, msg_count, (m + 1) % 256);
         end
      end
   endtask

   task automatic test_random();
      int         r;
      logic [6:0] seg;
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 19);
         if (r < 10)      seg = 7'h7F;
         else if (r < 19) seg = pat[$urandom_range(1, 9)];
         else             seg = 7'($urandom);
         step(1'($urandom_range(0, 3) != 0), seg, 1'($urandom_range(0, 1)));
         checks++;
         if (char_valid !== exp_valid || (exp_valid && char_code !== 5'(exp_code))) begin
            failures++;
            $display("FAIL rnd_fifo[%0d] got valid=%b code=%0d exp valid=%b code=%0d",
                     n, char_valid, char_code, exp_valid, exp_code);
         end
         checks++;
         if (word_done !== m_word || msg_done !== m_msg || msg_count !== m_msgs) begin
            failures++;
            $display("FAIL rnd_bounds[%0d] got word=%b msg=%b cnt=%0d exp word=%b msg=%b cnt=%0d",
                     n, word_done, msg_done, msg_count, m_word, m_msg, m_msgs);
         end
         checks++;
         if (decode_err !== m_err || overflow !== m_ovf) begin
            failures++;
            $display("FAIL rnd_flags[%0d] got err=%b ovf=%b exp err=%b ovf=%b",
                     n, decode_err, overflow, m_err, m_ovf);
         end
      end
   endtask

`ifdef SCROLL_MIRROR_EN
   task automatic test_mirror();
      do_reset();
      step(1'b1, P_C, 1'b1);
      step(1'b1, P_P, 1'b1);
      checks++;
      if (mirror_hex0 !== P_P || mirror_hex1 !== P_C) begin
         failures++;
         $display("FAIL mirror_low got hex0=%b hex1=%b exp hex0=%b hex1=%b",
                  mirror_hex0, mirror_hex1, P_P, P_C);
      end
      checks++;
      if ({mirror_hex2, mirror_hex3, mirror_hex4, mirror_hex5} !== {4{P_OFF}}) begin
         failures++;
         $display("FAIL mirror_high got %h %h %h %h exp 7f",
                  mirror_hex2, mirror_hex3, mirror_hex4, mirror_hex5);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_word();
      test_message();
      test_overflow();
      test_decode_err();
      test_async_reset();
      test_msg_wrap();
      test_random();
`ifdef SCROLL_MIRROR_EN
      test_mirror();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
